// File: rtl/ftile_xcvr_reset_responder_if.sv
// ---------------------------------------------------------------------------
// ftile_xcvr_reset_responder_if
//
// Reset/ready conduit between a reset controller and a transceiver
// (or its behavioural stand-in).
//
// Signals
//   tx_pll_locked, rx_signal_detect : physical status into the responder
//   tx_reset, rx_reset              : reset requests from the controller
//   tx_reset_ack, rx_reset_ack      : reset acknowledges
//   tx_ready, rx_ready              : datapath ready
//   rx_is_lockedtoref/_lockedtodata : CDR lock status
//   tx_reset_cnt, rx_reset_cnt      : saturating request rising-edge counts
//   rx_loss_cnt                     : saturating signal-loss drop count
//   proto_err                       : sticky early-withdrawal flag
//
// Modports
//   master : controller side (drives requests and physical status)
//   slave  : responder side (drives acks, ready, lock status and counters)
// ---------------------------------------------------------------------------
interface ftile_xcvr_reset_responder_if #(
  parameter int CNT_W = 8
);
  logic             tx_pll_locked;
  logic             rx_signal_detect;
  logic             tx_reset;
  logic             tx_reset_ack;
  logic             tx_ready;
  logic             rx_reset;
  logic             rx_reset_ack;
  logic             rx_ready;
  logic             rx_is_lockedtoref;
  logic             rx_is_lockedtodata;
  logic [CNT_W-1:0] tx_reset_cnt;
  logic [CNT_W-1:0] rx_reset_cnt;
  logic [CNT_W-1:0] rx_loss_cnt;
  logic             proto_err;

  modport master (
    output tx_pll_locked, rx_signal_detect, tx_reset, rx_reset,
    input  tx_reset_ack, tx_ready, rx_reset_ack, rx_ready,
           rx_is_lockedtoref, rx_is_lockedtodata,
           tx_reset_cnt, rx_reset_cnt, rx_loss_cnt, proto_err
  );

  modport slave (
    input  tx_pll_locked, rx_signal_detect, tx_reset, rx_reset,
    output tx_reset_ack, tx_ready, rx_reset_ack, rx_ready,
           rx_is_lockedtoref, rx_is_lockedtodata,
           tx_reset_cnt, rx_reset_cnt, rx_loss_cnt, proto_err
  );
endinterface

// File: rtl/ftile_xcvr_reset_responder.sv
// ---------------------------------------------------------------------------
// ftile_xcvr_reset_responder
//
// Behavioural transceiver-side responder for the F-tile reset/ready
// conduit. Acknowledges TX/RX reset requests after ACK_DELAY, raises
// tx_ready after TX_READY_DELAY cycles of continuous PLL lock, walks the RX
// side through lock-to-reference (LTR_DELAY) and lock-to-data (LTD_DELAY of
// continuous signal detect), and keeps saturating event counters plus a
// sticky protocol-error flag. TX and RX sides run independently.
//
// Ports
//   clk   : single clock
//   reset : synchronous, active-high; clears every output and both FSMs
//   xcvr  : conduit (slave modport), see ftile_xcvr_reset_responder_if
// ---------------------------------------------------------------------------
module ftile_xcvr_reset_responder #(
  parameter int ACK_DELAY      = 4,
  parameter int TX_READY_DELAY = 16,
  parameter int LTR_DELAY      = 8,
  parameter int LTD_DELAY      = 32,
  parameter int CNT_W          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  ftile_xcvr_reset_responder_if.slave   xcvr
);

  localparam logic [2:0] TX_NOTREADY = 3'd0;
  localparam logic [2:0] TX_ACK_WAIT = 3'd1;
  localparam logic [2:0] TX_ACKED    = 3'd2;
  localparam logic [2:0] TX_RELEASE  = 3'd3;
  localparam logic [2:0] TX_READY    = 3'd4;

  localparam logic [2:0] RX_NOTREADY  = 3'd0;
  localparam logic [2:0] RX_ACK_WAIT  = 3'd1;
  localparam logic [2:0] RX_ACKED     = 3'd2;
  localparam logic [2:0] RX_LOCK_REF  = 3'd3;
  localparam logic [2:0] RX_LOCK_DATA = 3'd4;
  localparam logic [2:0] RX_READY     = 3'd5;

  localparam int TX_MAX = (ACK_DELAY > TX_READY_DELAY) ? ACK_DELAY : TX_READY_DELAY;
  localparam int RX_M1  = (ACK_DELAY > LTR_DELAY) ? ACK_DELAY : LTR_DELAY;
  localparam int RX_MAX = (RX_M1 > LTD_DELAY) ? RX_M1 : LTD_DELAY;
  localparam int TX_CW  = $clog2(TX_MAX + 1);
  localparam int RX_CW  = $clog2(RX_MAX + 1);

  localparam logic [TX_CW-1:0] TX_ACK_LAST = TX_CW'(ACK_DELAY - 1);
  localparam logic [TX_CW-1:0] TX_RDY_LAST = TX_CW'(TX_READY_DELAY - 1);
  localparam logic [RX_CW-1:0] RX_ACK_LAST = RX_CW'(ACK_DELAY - 1);
  localparam logic [RX_CW-1:0] RX_LTR_LAST = RX_CW'(LTR_DELAY - 1);
  localparam logic [RX_CW-1:0] RX_LTD_LAST = RX_CW'(LTD_DELAY - 1);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]       tx_state, tx_state_nxt;
  logic [TX_CW-1:0] tx_cnt, tx_cnt_nxt;
  logic             tx_err_set;
  logic [2:0]       rx_state, rx_state_nxt;
  logic [RX_CW-1:0] rx_cnt, rx_cnt_nxt;
  logic             rx_err_set;
  logic             rx_loss_evt;

  logic             tx_reset_p1, rx_reset_p1;
  logic             tx_reset_ack_r, tx_ready_r;
  logic             rx_reset_ack_r, rx_ready_r, rx_ltr_r, rx_ltd_r;
  logic [CNT_W-1:0] tx_reset_cnt_r, rx_reset_cnt_r, rx_loss_cnt_r;
  logic             proto_err_r;

  // TX next-state. A new request always restarts the handshake, even from
  // RELEASE/READY; withdrawal during ACK_WAIT is flagged and skips the ack.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_err_set   = 1'b0;
    case (tx_state)
      TX_NOTREADY: begin
        if (xcvr.tx_reset) begin
          tx_state_nxt = TX_ACK_WAIT;
          tx_cnt_nxt   = '0;
        end
      end
      TX_ACK_WAIT: begin
        if (!xcvr.tx_reset) begin
          tx_state_nxt = TX_RELEASE;
          tx_cnt_nxt   = '0;
          tx_err_set   = 1'b1;
        end else if (tx_cnt == TX_ACK_LAST) begin
          tx_state_nxt = TX_ACKED;
          tx_cnt_nxt   = '0;
        end else begin
          tx_cnt_nxt   = tx_cnt + 1'b1;
        end
      end
      TX_ACKED: begin
        if (!xcvr.tx_reset) begin
          tx_state_nxt = TX_RELEASE;
          tx_cnt_nxt   = '0;
        end
      end
      TX_RELEASE: begin
        if (xcvr.tx_reset) begin
          tx_state_nxt = TX_ACK_WAIT;
          tx_cnt_nxt   = '0;
        end else if (!xcvr.tx_pll_locked) begin
          // Lock must be continuous: any drop restarts the qualification.
          tx_cnt_nxt   = '0;
        end else if (tx_cnt == TX_RDY_LAST) begin
          tx_state_nxt = TX_READY;
          tx_cnt_nxt   = '0;
        end else begin
          tx_cnt_nxt   = tx_cnt + 1'b1;
        end
      end
      TX_READY: begin
        if (xcvr.tx_reset) begin
          tx_state_nxt = TX_ACK_WAIT;
          tx_cnt_nxt   = '0;
        end else if (!xcvr.tx_pll_locked) begin
          tx_state_nxt = TX_RELEASE;
          tx_cnt_nxt   = '0;
        end
      end
      default: begin
        tx_state_nxt = TX_NOTREADY;
        tx_cnt_nxt   = '0;
      end
    endcase
  end

  // RX next-state. A request preempts any lock progress; signal loss in
  // READY falls back to LOCK_DATA and is counted.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_err_set   = 1'b0;
    rx_loss_evt  = 1'b0;
    case (rx_state)
      RX_NOTREADY: begin
        if (xcvr.rx_reset) begin
          rx_state_nxt = RX_ACK_WAIT;
          rx_cnt_nxt   = '0;
        end
      end
      RX_ACK_WAIT: begin
        if (!xcvr.rx_reset) begin
          rx_state_nxt = RX_LOCK_REF;
          rx_cnt_nxt   = '0;
          rx_err_set   = 1'b1;
        end else if (rx_cnt == RX_ACK_LAST) begin
          rx_state_nxt = RX_ACKED;
          rx_cnt_nxt   = '0;
        end else begin
          rx_cnt_nxt   = rx_cnt + 1'b1;
        end
      end
      RX_ACKED: begin
        if (!xcvr.rx_reset) begin
          rx_state_nxt = RX_LOCK_REF;
          rx_cnt_nxt   = '0;
        end
      end
      RX_LOCK_REF: begin
        if (xcvr.rx_reset) begin
          rx_state_nxt = RX_ACK_WAIT;
          rx_cnt_nxt   = '0;
        end else if (rx_cnt == RX_LTR_LAST) begin
          rx_state_nxt = RX_LOCK_DATA;
          rx_cnt_nxt   = '0;
        end else begin
          rx_cnt_nxt   = rx_cnt + 1'b1;
        end
      end
      RX_LOCK_DATA: begin
        if (xcvr.rx_reset) begin
          rx_state_nxt = RX_ACK_WAIT;
          rx_cnt_nxt   = '0;
        end else if (!xcvr.rx_signal_detect) begin
          rx_cnt_nxt   = '0;
        end else if (rx_cnt == RX_LTD_LAST) begin
          rx_state_nxt = RX_READY;
          rx_cnt_nxt   = '0;
        end else begin
          rx_cnt_nxt   = rx_cnt + 1'b1;
        end
      end
      RX_READY: begin
        if (xcvr.rx_reset) begin
          rx_state_nxt = RX_ACK_WAIT;
          rx_cnt_nxt   = '0;
        end else if (!xcvr.rx_signal_detect) begin
          rx_state_nxt = RX_LOCK_DATA;
          rx_cnt_nxt   = '0;
          rx_loss_evt  = 1'b1;
        end
      end
      default: begin
        rx_state_nxt = RX_NOTREADY;
        rx_cnt_nxt   = '0;
      end
    endcase
  end

  // Ack follows the current state (one edge after entering ACKED); ready and
  // lock flags follow the next state so they move on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state       <= TX_NOTREADY;
      tx_cnt         <= '0;
      rx_state       <= RX_NOTREADY;
      rx_cnt         <= '0;
      tx_reset_p1    <= 1'b0;
      rx_reset_p1    <= 1'b0;
      tx_reset_ack_r <= 1'b0;
      tx_ready_r     <= 1'b0;
      rx_reset_ack_r <= 1'b0;
      rx_ready_r     <= 1'b0;
      rx_ltr_r       <= 1'b0;
      rx_ltd_r       <= 1'b0;
      tx_reset_cnt_r <= '0;
      rx_reset_cnt_r <= '0;
      rx_loss_cnt_r  <= '0;
      proto_err_r    <= 1'b0;
    end else begin
      tx_state       <= tx_state_nxt;
      tx_cnt         <= tx_cnt_nxt;
      rx_state       <= rx_state_nxt;
      rx_cnt         <= rx_cnt_nxt;
      tx_reset_p1    <= xcvr.tx_reset;
      rx_reset_p1    <= xcvr.rx_reset;
      tx_reset_ack_r <= (tx_state == TX_ACKED) && xcvr.tx_reset;
      tx_ready_r     <= (tx_state_nxt == TX_READY);
      rx_reset_ack_r <= (rx_state == RX_ACKED) && xcvr.rx_reset;
      rx_ltr_r       <= (rx_state_nxt == RX_LOCK_DATA) || (rx_state_nxt == RX_READY);
      rx_ltd_r       <= (rx_state_nxt == RX_READY);
      rx_ready_r     <= (rx_state_nxt == RX_READY);
      if (xcvr.tx_reset && !tx_reset_p1) tx_reset_cnt_r <= sat_inc(tx_reset_cnt_r);
      if (xcvr.rx_reset && !rx_reset_p1) rx_reset_cnt_r <= sat_inc(rx_reset_cnt_r);
      if (rx_loss_evt)                   rx_loss_cnt_r  <= sat_inc(rx_loss_cnt_r);
      proto_err_r    <= proto_err_r | tx_err_set | rx_err_set;
    end
  end

  assign xcvr.tx_reset_ack       = tx_reset_ack_r;
  assign xcvr.tx_ready           = tx_ready_r;
  assign xcvr.rx_reset_ack       = rx_reset_ack_r;
  assign xcvr.rx_ready           = rx_ready_r;
  assign xcvr.rx_is_lockedtoref  = rx_ltr_r;
  assign xcvr.rx_is_lockedtodata = rx_ltd_r;
  assign xcvr.tx_reset_cnt       = tx_reset_cnt_r;
  assign xcvr.rx_reset_cnt       = rx_reset_cnt_r;
  assign xcvr.rx_loss_cnt        = rx_loss_cnt_r;
  assign xcvr.proto_err          = proto_err_r;

endmodule

// File: tb/tb_ftile_xcvr_reset_responder.sv
// ---------------------------------------------------------------------------
// tb_ftile_xcvr_reset_responder
//
// Each record holds the inputs to drive, how many clock edges to hold them,
// and the outputs expected after the last of those edges. Expected records
// are queued when their stimulus is driven and popped once the edges have
// elapsed. Default parameters: ACK_DELAY=4, TX_READY_DELAY=16, LTR_DELAY=8,
// LTD_DELAY=32, CNT_W=8.
// ---------------------------------------------------------------------------
module tb_ftile_xcvr_reset_responder;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ftile_xcvr_reset_responder_if #(.CNT_W(CNT_W)) bus ();

  ftile_xcvr_reset_responder #(
    .ACK_DELAY(4), .TX_READY_DELAY(16), .LTR_DELAY(8), .LTD_DELAY(32), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .xcvr (bus)
  );

  typedef struct {
    int   n;
    logic txr, lock, rxr, det;
    logic ack_t, rdy_t, ack_r, ltr, ltd, rdy_r, perr;
    int   txc, rxc, lossc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(int n, logic txr, logic lock, logic rxr, logic det,
                              logic ack_t, logic rdy_t, logic ack_r, logic ltr,
                              logic ltd, logic rdy_r, logic perr,
                              int txc, int rxc, int lossc);
    vec_t v;
    v.n = n; v.txr = txr; v.lock = lock; v.rxr = rxr; v.det = det;
    v.ack_t = ack_t; v.rdy_t = rdy_t; v.ack_r = ack_r; v.ltr = ltr;
    v.ltd = ltd; v.rdy_r = rdy_r; v.perr = perr;
    v.txc = txc; v.rxc = rxc; v.lossc = lossc;
    return v;
  endfunction

  task automatic cmp(input string tag, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d", tag, nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp(tag, "tx_reset_ack", int'(bus.tx_reset_ack), 0);
    cmp(tag, "tx_ready", int'(bus.tx_ready), 0);
    cmp(tag, "rx_reset_ack", int'(bus.rx_reset_ack), 0);
    cmp(tag, "rx_is_lockedtoref", int'(bus.rx_is_lockedtoref), 0);
    cmp(tag, "rx_is_lockedtodata", int'(bus.rx_is_lockedtodata), 0);
    cmp(tag, "rx_ready", int'(bus.rx_ready), 0);
    cmp(tag, "proto_err", int'(bus.proto_err), 0);
    cmp(tag, "tx_reset_cnt", int'(bus.tx_reset_cnt), 0);
    cmp(tag, "rx_reset_cnt", int'(bus.rx_reset_cnt), 0);
    cmp(tag, "rx_loss_cnt", int'(bus.rx_loss_cnt), 0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    sb.push_back(v);
    bus.tx_reset         = v.txr;
    bus.tx_pll_locked    = v.lock;
    bus.rx_reset         = v.rxr;
    bus.rx_signal_detect = v.det;
    repeat (v.n) @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp(tag, "tx_reset_ack", int'(bus.tx_reset_ack), int'(e.ack_t));
    cmp(tag, "tx_ready", int'(bus.tx_ready), int'(e.rdy_t));
    cmp(tag, "rx_reset_ack", int'(bus.rx_reset_ack), int'(e.ack_r));
    cmp(tag, "rx_is_lockedtoref", int'(bus.rx_is_lockedtoref), int'(e.ltr));
    cmp(tag, "rx_is_lockedtodata", int'(bus.rx_is_lockedtodata), int'(e.ltd));
    cmp(tag, "rx_ready", int'(bus.rx_ready), int'(e.rdy_r));
    cmp(tag, "proto_err", int'(bus.proto_err), int'(e.perr));
    cmp(tag, "tx_reset_cnt", int'(bus.tx_reset_cnt), e.txc);
    cmp(tag, "rx_reset_cnt", int'(bus.rx_reset_cnt), e.rxc);
    cmp(tag, "rx_loss_cnt", int'(bus.rx_loss_cnt), e.lossc);
  endtask

  initial begin
    //          n  txr lk rxr det ackT rdyT ackR ltr ltd rdyR perr txc rxc loss
    // Basic TX handshake: ack 5 edges after first request sample, ready 16 after release
    tbl.push_back(mk( 3, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk( 4, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 3, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(15, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0,  1, 0, 0));
    // PLL loss for 5 cycles, ready back 16 cycles after relock
    tbl.push_back(mk( 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 4, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(15, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0,  1, 0, 0));
    // Lock glitch in RELEASE restarts the qualification count
    tbl.push_back(mk( 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(10, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk(15, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0,  1, 0, 0));
    // RX sequence: ack, lockedtoref 8 after release, lockedtodata/ready 32 later
    tbl.push_back(mk( 5, 0, 1, 1, 1,  0, 1, 0, 0, 0, 0, 0,  1, 1, 0));
    tbl.push_back(mk( 1, 0, 1, 1, 1,  0, 1, 1, 0, 0, 0, 0,  1, 1, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0,  1, 1, 0));
    tbl.push_back(mk( 7, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 0,  1, 1, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0,  1, 1, 0));
    tbl.push_back(mk(31, 0, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0,  1, 1, 0));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 1, 0, 1, 1, 1, 0,  1, 1, 0));
    // RX signal loss for one cycle, relock after 32
    tbl.push_back(mk( 1, 0, 1, 0, 0,  0, 1, 0, 1, 0, 0, 0,  1, 1, 1));
    tbl.push_back(mk(31, 0, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0,  1, 1, 1));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 1, 0, 1, 1, 1, 0,  1, 1, 1));
    // TX request withdrawn after 2 cycles: sticky proto_err, no ack
    tbl.push_back(mk( 2, 1, 1, 0, 1,  0, 0, 0, 1, 1, 1, 0,  2, 1, 1));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 0, 0, 1, 1, 1, 1,  2, 1, 1));
    tbl.push_back(mk(10, 0, 1, 0, 1,  0, 0, 0, 1, 1, 1, 1,  2, 1, 1));
    tbl.push_back(mk( 5, 0, 1, 0, 1,  0, 0, 0, 1, 1, 1, 1,  2, 1, 1));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 1, 0, 1, 1, 1, 1,  2, 1, 1));
    // RX re-request in READY: status drops next cycle, new ack after 5 edges
    tbl.push_back(mk( 1, 0, 1, 1, 1,  0, 1, 0, 0, 0, 0, 1,  2, 2, 1));
    tbl.push_back(mk( 4, 0, 1, 1, 1,  0, 1, 0, 0, 0, 0, 1,  2, 2, 1));
    tbl.push_back(mk( 1, 0, 1, 1, 1,  0, 1, 1, 0, 0, 0, 1,  2, 2, 1));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 1, 0, 0, 0, 0, 1,  2, 2, 1));
    // Simultaneous TX and RX requests serviced in parallel
    tbl.push_back(mk( 5, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 1,  3, 3, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 1,  1, 0, 1, 0, 0, 0, 1,  3, 3, 1));
    tbl.push_back(mk( 1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1,  3, 3, 1));

    reset                = 1'b1;
    bus.tx_reset         = 1'b0;
    bus.tx_pll_locked    = 1'b0;
    bus.rx_reset         = 1'b0;
    bus.rx_signal_detect = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // 300 more tx_reset pulses: counter must stick at 255, not wrap
    bus.tx_pll_locked    = 1'b1;
    bus.rx_reset         = 1'b0;
    bus.rx_signal_detect = 1'b1;
    for (int p = 0; p < 300; p++) begin
      bus.tx_reset = 1'b1;
      @(posedge clk); #1;
      bus.tx_reset = 1'b0;
      @(posedge clk); #1;
    end
    apply(mk(1, 0, 1, 0, 1,  0, 0, 0, 1, 1, 1, 1,  255, 3, 1), "sat");

    // Reset while TX is in ACKED
    apply(mk(6, 1, 1, 0, 1,  1, 0, 0, 1, 1, 1, 1,  255, 3, 1), "pre_rst_acked");
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_reset");
    reset = 1'b0;
    // Request still held: full handshake restarts from NOTREADY
    apply(mk(5, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0), "post_rst_wait");
    apply(mk(1, 1, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0,  1, 0, 0), "post_rst_ack");

    // RX withdrawal sets proto_err and moves straight to lock-to-reference
    bus.tx_reset = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    apply(mk(2, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0), "rx_wd_req");
    apply(mk(1, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1,  0, 1, 0), "rx_wd_err");
    apply(mk(7, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1,  0, 1, 0), "rx_wd_noack");
    apply(mk(1, 0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 1,  0, 1, 0), "rx_wd_ltr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
